div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter_if.sv | 29 ++
 rtl/div_iter.sv | 143 ++++++++++++++
 tb/tb_div_iter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// div_iter_if
// Bundles the divider request/result signals so the requester and the divider
// share one port.
//   master : drives start, signed_mode, dividend and divisor; observes the results
//   slave  : the divider side; drives busy, done, quotient, remainder and div_by_zero
// WIDTH is the operand/result width and must match the divider's WIDTH.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_iter.sv
// div_iter
// Iterative restoring divider. It handles signed and unsigned operands and
// produces one quotient bit per clock.
//   clk   : single clock; all state changes happen on the rising edge
//   rst_n : synchronous, active-low reset
//   bus   : div_iter_if slave modport
//             start/signed_mode/dividend/divisor : request, sampled on acceptance
//             busy        : high while a division is in progress
//             done        : one-cycle pulse when the results are valid
//             quotient    : registered result
//             remainder   : registered result
//             div_by_zero : registered flag, set when the divisor was zero
// A division takes WIDTH iteration cycles followed by one cycle that fixes the
// signs. Done is therefore raised WIDTH+1 edges after the edge that accepted start.
module div_iter #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  div_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] dividend_q;
  logic             negQ_q;
  logic             negR_q;
  logic             divZero_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;

  // Compute the operand magnitudes at acceptance. When the operand is the most
  // negative value, its negation wraps back onto itself. Read as unsigned, that
  // pattern is still the correct magnitude.
  always_comb begin
    aNeg = bus.signed_mode & bus.dividend[WIDTH-1];
    bNeg = bus.signed_mode & bus.divisor[WIDTH-1];
    aMag = aNeg ? -bus.dividend : bus.dividend;
    bMag = bNeg ? -bus.divisor : bus.divisor;
  end

  // One restoring step. The quotient register starts out holding the dividend,
  // and the dividend bits shift out of its MSB into the partial remainder.
  // The remainder is WIDTH+1 bits wide, so the shifted value always fits even
  // when the divisor has its MSB set.
  always_comb begin
    shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    fits    = shifted >= {1'b0, divisor_q};
    rem_d   = fits ? (shifted - {1'b0, divisor_q}) : shifted;
    quo_d   = {quo_q[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      dividend_q  <= '0;
      negQ_q      <= 1'b0;
      negR_q      <= 1'b0;
      divZero_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q    <= CALC;
            busy_q     <= 1'b1;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= aMag;
            divisor_q  <= bMag;
            dividend_q <= bus.dividend;
            negQ_q     <= aNeg ^ bNeg;
            negR_q     <= aNeg;
            divZero_q  <= (bus.divisor == '0);
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (count_q == CW'(WIDTH)) begin
            // This is the sign-fixup cycle. A zero divisor bypasses the
            // iteration result and returns the raw dividend as the remainder.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dz_q    <= divZero_q;
            if (divZero_q) begin
              quotient_q  <= '1;
              remainder_q <= dividend_q;
            end else begin
              quotient_q  <= negQ_q ? -quo_q : quo_q;
              remainder_q <= negR_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            end
          end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            count_q <= count_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter
// Directed testbench for div_iter with WIDTH=32. It applies a table of
// hand-computed vectors, then runs sequences for the start-during-CALC case,
// back-to-back operation and mid-operation reset.
module tb_div_iter;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  div_iter_if #(.WIDTH(W)) bus ();

  div_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  // Compare one observed value against its expected value and record the result.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Start one division, release start after the accepting edge, then count edges
  // until done. The count is capped so that a divider which never finishes
  // still lets the bench reach its summary line.
  task automatic applyStimulus(input logic sm, input logic [31:0] a, input logic [31:0] b,
                               output int edges);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.signed_mode = sm;
    bus.dividend    = a;
    bus.divisor     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    edges = 0;
    while (!bus.done && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Count edges until done, continuing from a count already in progress.
  task automatic waitDone(input int startEdges, output int edges);
    edges = startEdges;
    while (!bus.done && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic checkResult(input string tag, input int edges, input logic [31:0] q,
                             input logic [31:0] r, input logic dz);
    checkOutput({tag, " latency"}, 64'(edges), 64'(LAT));
    checkOutput({tag, " quotient"}, 64'(bus.quotient), 64'(q));
    checkOutput({tag, " remainder"}, 64'(bus.remainder), 64'(r));
    checkOutput({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(dz));
    checkOutput({tag, " busy at done"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    int edges;
    bit sawDone;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[3]  = '{1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};
    vecs[4]  = '{1'b0, 32'd10,         32'd3,          32'd3,          32'd1,          1'b0};
    vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[9]  = '{1'b1, 32'h80000000,   32'd0,          32'hFFFFFFFF,   32'h80000000,   1'b1};
    vecs[10] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
    vecs[11] = '{1'b0, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          1'b0};

    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend    = '0;
    bus.divisor     = '0;

    // Power-up reset
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(bus.busy), 64'(0));
    checkOutput("reset done", 64'(bus.done), 64'(0));
    checkOutput("reset quotient", 64'(bus.quotient), 64'(0));
    checkOutput("reset remainder", 64'(bus.remainder), 64'(0));
    checkOutput("reset div_by_zero", 64'(bus.div_by_zero), 64'(0));
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sm, vecs[i].a, vecs[i].b, edges);
      checkResult($sformatf("v%0d", i), edges, vecs[i].q, vecs[i].r, vecs[i].dz);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d done one cycle", i), 64'(bus.done), 64'(0));
      checkOutput($sformatf("v%0d quotient held", i), 64'(bus.quotient), 64'(vecs[i].q));
    end

    // A start pulse during CALC must not disturb the operation in progress
    @(negedge clk);
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    edges = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      edges++;
    end
    bus.start = 1'b1; bus.dividend = 32'd1; bus.divisor = 32'd1; bus.signed_mode = 1'b1;
    @(posedge clk);
    #1;
    edges++;
    bus.start = 1'b0;
    checkOutput("calc start busy", 64'(bus.busy), 64'(1));
    waitDone(edges, edges);
    checkResult("ignore start", edges, 32'd14, 32'd2, 1'b0);

    // Back-to-back: start is already high in the DONE cycle
    applyStimulus(1'b0, 32'd1000, 32'd10, edges);
    checkResult("b2b first", edges, 32'd100, 32'd0, 1'b0);
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd8;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("b2b busy after accept", 64'(bus.busy), 64'(1));
    checkOutput("b2b done after accept", 64'(bus.done), 64'(0));
    waitDone(0, edges);
    checkResult("b2b second", edges, 32'd6, 32'd2, 1'b0);

    // Reset ten edges into an operation, with start held high while reset is active
    @(negedge clk);
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("mid reset busy", 64'(bus.busy), 64'(0));
    checkOutput("mid reset done", 64'(bus.done), 64'(0));
    checkOutput("mid reset quotient", 64'(bus.quotient), 64'(0));
    checkOutput("mid reset remainder", 64'(bus.remainder), 64'(0));
    checkOutput("mid reset div_by_zero", 64'(bus.div_by_zero), 64'(0));
    bus.start = 1'b0;
    rst_n = 1'b1;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) sawDone = 1'b1;
    end
    checkOutput("no done after reset", 64'(sawDone), 64'(0));
    checkOutput("idle after reset", 64'(bus.busy), 64'(0));
    applyStimulus(1'b0, 32'd9, 32'd4, edges);
    checkResult("after reset", edges, 32'd2, 32'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
